control_unit: RTL and testbench

- Multicycle control FSM for the MIPS-subset CPU datapath. It is the producer side of the datapath's control interface.
- Consumes the IR fields (OPCODE, funct = OFFSET[5:0]) and the ULA flags.
- Drives every write enable, ULA operation code and mux select the datapath expects.
- Also sources the exception-vector address used by the memory address mux.

---
 rtl/control_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_control_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//    Multicycle control FSM for the MIPS-subset CPU. It walks every instruction
//    through fetch, decode and execute states and drives the datapath's write
//    enables, ULA operation code and mux selects. It also holds the address of
//    the exception handler pointer (exc_vec) for the memory address mux.
//
// Ports
//    clk        system clock, all state changes on the rising edge
//    reset      synchronous, active-low reset
//    OPCODE     IR[31:26]
//    funct      IR[5:0]
//    Of, Eq     ULA overflow / equal flags for the current cycle
//    PC_w, MEM_w, IR_w, RB_w, AB_w, ALUOut_w, EPC_w   write enables
//    ULA_c      001 add, 010 sub, 011 and, 111 compare, 000 otherwise
//    M_WREG     register file write address select (0 rt, 1 rd)
//    M_WDATA    register file write data select (00 ALUOut, 01 memory)
//    M_ULAA     ULA A select (00 PC, 01 A)
//    M_ULAB     ULA B select (00 B, 01 const 4, 10 sign-ext, 11 sign-ext<<2)
//    M_PC_src   PC source (000 ULA, 001 ALUOut, 010 jump, 011 mem, 100 EPC)
//    Mux_addr   memory address select (00 PC, 01 ULA, 10 ALUOut, 11 exc_vec)
//    exc_vec    last selected exception vector, 0 after reset
//    state      current state encoding for debug; RST is always encoded 0
// -----------------------------------------------------------------------------
module control_unit #(
   parameter logic [31:0] VEC_OPCODE = 32'd253,
   parameter logic [31:0] VEC_OVF    = 32'd254
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  OPCODE,
   input  logic [5:0]  funct,
   input  logic        Of,
   input  logic        Eq,
   output logic        PC_w,
   output logic        MEM_w,
   output logic        IR_w,
   output logic        RB_w,
   output logic        AB_w,
   output logic        ALUOut_w,
   output logic        EPC_w,
   output logic [2:0]  ULA_c,
   output logic        M_WREG,
   output logic [1:0]  M_WDATA,
   output logic [1:0]  M_ULAA,
   output logic [1:0]  M_ULAB,
   output logic [2:0]  M_PC_src,
   output logic [1:0]  Mux_addr,
   output logic [31:0] exc_vec,
   output logic [4:0]  state
);

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_RTE  = 6'h10;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;

   typedef enum logic [4:0] {
      S_RST      = 5'd0,
      S_FETCH1   = 5'd1,
      S_FETCH2   = 5'd2,
      S_DECODE   = 5'd3,
      S_EXEC_R   = 5'd4,
      S_WB_R     = 5'd5,
      S_ADDI     = 5'd6,
      S_WB_I     = 5'd7,
      S_MEM_ADDR = 5'd8,
      S_LW_RD1   = 5'd9,
      S_LW_RD2   = 5'd10,
      S_LW_WB    = 5'd11,
      S_SW_WR    = 5'd12,
      S_BRANCH   = 5'd13,
      S_JUMP     = 5'd14,
      S_RTE      = 5'd15,
      S_EXC_OP   = 5'd16,
      S_EXC_OVF  = 5'd17,
      S_EXC_RD1  = 5'd18,
      S_EXC_RD2  = 5'd19,
      S_EXC_LD   = 5'd20
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_excVec;
   logic        w_validR;

   assign w_validR = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
   assign exc_vec  = r_excVec;
   assign state    = r_state;

   // State register and exception vector. A low reset forces RST and clears
   // the vector regardless of where the current instruction is. The vector
   // is latched while leaving an exception-entry state, so the three
   // handler-pointer read cycles that follow already see the new address.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_RST;
         r_excVec <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == S_EXC_OP)
            r_excVec <= VEC_OPCODE;
         else if (r_state == S_EXC_OVF)
            r_excVec <= VEC_OVF;
      end
   end

   // Output decode and next-state selection. Everything defaults to 0 and
   // falls back to FETCH1, so each state only lists what it turns on. The
   // branch write enable is the one output that also looks at a ULA flag in
   // the same cycle.
   always_comb begin
      PC_w        = 1'b0;
      MEM_w       = 1'b0;
      IR_w        = 1'b0;
      RB_w        = 1'b0;
      AB_w        = 1'b0;
      ALUOut_w    = 1'b0;
      EPC_w       = 1'b0;
      ULA_c       = 3'b000;
      M_WREG      = 1'b0;
      M_WDATA     = 2'b00;
      M_ULAA      = 2'b00;
      M_ULAB      = 2'b00;
      M_PC_src    = 3'b000;
      Mux_addr    = 2'b00;
      w_nextState = S_FETCH1;

      case (r_state)
         S_RST: begin
         end
         S_FETCH1: begin
            w_nextState = S_FETCH2;
         end
         S_FETCH2: begin
            IR_w        = 1'b1;
            PC_w        = 1'b1;
            M_ULAB      = 2'b01;
            ULA_c       = 3'b001;
            w_nextState = S_DECODE;
         end
         S_DECODE: begin
            AB_w     = 1'b1;
            ALUOut_w = 1'b1;
            M_ULAB   = 2'b11;
            ULA_c    = 3'b001;
            case (OPCODE)
               OP_R:          w_nextState = w_validR ? S_EXEC_R : S_EXC_OP;
               OP_ADDI:       w_nextState = S_ADDI;
               OP_LW, OP_SW:  w_nextState = S_MEM_ADDR;
               OP_BEQ, OP_BNE: w_nextState = S_BRANCH;
               OP_J:          w_nextState = S_JUMP;
               OP_RTE:        w_nextState = S_RTE;
               default:       w_nextState = S_EXC_OP;
            endcase
         end
         S_EXEC_R: begin
            M_ULAA   = 2'b01;
            ALUOut_w = 1'b1;
            case (funct)
               FN_ADD:  ULA_c = 3'b001;
               FN_SUB:  ULA_c = 3'b010;
               FN_AND:  ULA_c = 3'b011;
               default: ULA_c = 3'b000;
            endcase
            // A logical and cannot overflow, so its Of is meaningless.
            w_nextState = (Of && (funct != FN_AND)) ? S_EXC_OVF : S_WB_R;
         end
         S_WB_R: begin
            RB_w   = 1'b1;
            M_WREG = 1'b1;
         end
         S_ADDI: begin
            M_ULAA      = 2'b01;
            M_ULAB      = 2'b10;
            ULA_c       = 3'b001;
            ALUOut_w    = 1'b1;
            w_nextState = Of ? S_EXC_OVF : S_WB_I;
         end
         S_WB_I: begin
            RB_w = 1'b1;
         end
         S_MEM_ADDR: begin
            M_ULAA      = 2'b01;
            M_ULAB      = 2'b10;
            ULA_c       = 3'b001;
            ALUOut_w    = 1'b1;
            w_nextState = (OPCODE == OP_LW) ? S_LW_RD1 : S_SW_WR;
         end
         S_LW_RD1: begin
            Mux_addr    = 2'b10;
            w_nextState = S_LW_RD2;
         end
         S_LW_RD2: begin
            Mux_addr    = 2'b10;
            w_nextState = S_LW_WB;
         end
         S_LW_WB: begin
            Mux_addr = 2'b10;
            RB_w     = 1'b1;
            M_WDATA  = 2'b01;
         end
         S_SW_WR: begin
            Mux_addr = 2'b10;
            MEM_w    = 1'b1;
         end
         S_BRANCH: begin
            M_ULAA   = 2'b01;
            ULA_c    = 3'b111;
            M_PC_src = 3'b001;
            PC_w     = (OPCODE == OP_BEQ) ? Eq : !Eq;
         end
         S_JUMP: begin
            PC_w     = 1'b1;
            M_PC_src = 3'b010;
         end
         S_RTE: begin
            PC_w     = 1'b1;
            M_PC_src = 3'b100;
         end
         S_EXC_OP, S_EXC_OVF: begin
            // EPC captures PC-4, i.e. the address of the faulting instruction.
            EPC_w       = 1'b1;
            M_ULAB      = 2'b01;
            ULA_c       = 3'b010;
            w_nextState = S_EXC_RD1;
         end
         S_EXC_RD1: begin
            Mux_addr    = 2'b11;
            w_nextState = S_EXC_RD2;
         end
         S_EXC_RD2: begin
            Mux_addr    = 2'b11;
            w_nextState = S_EXC_LD;
         end
         S_EXC_LD: begin
            Mux_addr = 2'b11;
            PC_w     = 1'b1;
            M_PC_src = 3'b011;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//    Directed and randomized instruction sequences for control_unit. For each
//    instruction the bench builds the expected per-cycle output trace from the
//    instruction-level rules (class of instruction, flag values in the
//    deciding cycle) and compares every cycle against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_control_unit;

   localparam logic [31:0] VEC_OPCODE = 32'd253;
   localparam logic [31:0] VEC_OVF    = 32'd254;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  OPCODE = 6'h00;
   logic [5:0]  funct = 6'h00;
   logic        Of = 1'b0;
   logic        Eq = 1'b0;
   logic        PC_w, MEM_w, IR_w, RB_w, AB_w, ALUOut_w, EPC_w;
   logic [2:0]  ULA_c;
   logic        M_WREG;
   logic [1:0]  M_WDATA, M_ULAA, M_ULAB;
   logic [2:0]  M_PC_src;
   logic [1:0]  Mux_addr;
   logic [31:0] exc_vec;
   logic [4:0]  state;

   control_unit #(.VEC_OPCODE(VEC_OPCODE), .VEC_OVF(VEC_OVF)) dut (
      .clk(clk), .reset(reset), .OPCODE(OPCODE), .funct(funct), .Of(Of), .Eq(Eq),
      .PC_w(PC_w), .MEM_w(MEM_w), .IR_w(IR_w), .RB_w(RB_w), .AB_w(AB_w),
      .ALUOut_w(ALUOut_w), .EPC_w(EPC_w), .ULA_c(ULA_c), .M_WREG(M_WREG),
      .M_WDATA(M_WDATA), .M_ULAA(M_ULAA), .M_ULAB(M_ULAB), .M_PC_src(M_PC_src),
      .Mux_addr(Mux_addr), .exc_vec(exc_vec), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        pcW, memW, irW, rbW, abW, aluOutW, epcW;
      logic [2:0]  ulaC;
      logic        mWreg;
      logic [1:0]  mWdata, mUlaA, mUlaB;
      logic [2:0]  mPcSrc;
      logic [1:0]  muxAddr;
      logic [31:0] excVec;
   } outs_t;

   int          checks = 0;
   int          errors = 0;
   int          instrNum = 0;
   outs_t       expQ[$];
   logic [31:0] modelExcVec = 32'd0;

   // Expected output bundle with nothing asserted.
   function automatic outs_t blank();
      outs_t o = '0;
      o.excVec = modelExcVec;
      return o;
   endfunction

   // Exception entry: save PC-4 into EPC, then read the handler pointer from
   // the vector address for three cycles and load it into PC.
   function automatic void pushException(input logic [31:0] vec);
      outs_t o;
      o = blank(); o.epcW = 1'b1; o.mUlaB = 2'b01; o.ulaC = 3'b010;
      expQ.push_back(o);
      modelExcVec = vec;
      for (int k = 0; k < 3; k++) begin
         o = blank(); o.muxAddr = 2'b11;
         if (k == 2) begin o.pcW = 1'b1; o.mPcSrc = 3'b011; end
         expQ.push_back(o);
      end
   endfunction

   // Full expected trace of one instruction; of3/eq3 are the flag values
   // presented in the cycle right after decode.
   function automatic void buildExpected(input logic [5:0] op, input logic [5:0] fn,
                                         input logic of3, input logic eq3);
      outs_t o;
      expQ.delete();
      o = blank(); expQ.push_back(o);
      o = blank(); o.irW = 1'b1; o.pcW = 1'b1; o.mUlaB = 2'b01; o.ulaC = 3'b001;
      expQ.push_back(o);
      o = blank(); o.abW = 1'b1; o.aluOutW = 1'b1; o.mUlaB = 2'b11; o.ulaC = 3'b001;
      expQ.push_back(o);
      case (op)
         6'h00: begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) begin
               o = blank(); o.mUlaA = 2'b01; o.aluOutW = 1'b1;
               o.ulaC = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
               expQ.push_back(o);
               if (of3 && fn != 6'h24) pushException(VEC_OVF);
               else begin
                  o = blank(); o.rbW = 1'b1; o.mWreg = 1'b1; expQ.push_back(o);
               end
            end else pushException(VEC_OPCODE);
         end
         6'h08, 6'h23, 6'h2B: begin
            o = blank(); o.mUlaA = 2'b01; o.mUlaB = 2'b10; o.ulaC = 3'b001; o.aluOutW = 1'b1;
            expQ.push_back(o);
            if (op == 6'h08) begin
               if (of3) pushException(VEC_OVF);
               else begin o = blank(); o.rbW = 1'b1; expQ.push_back(o); end
            end else if (op == 6'h23) begin
               for (int k = 0; k < 3; k++) begin
                  o = blank(); o.muxAddr = 2'b10;
                  if (k == 2) begin o.rbW = 1'b1; o.mWdata = 2'b01; end
                  expQ.push_back(o);
               end
            end else begin
               o = blank(); o.muxAddr = 2'b10; o.memW = 1'b1; expQ.push_back(o);
            end
         end
         6'h04, 6'h05: begin
            o = blank(); o.mUlaA = 2'b01; o.ulaC = 3'b111; o.mPcSrc = 3'b001;
            o.pcW = (op == 6'h04) ? eq3 : !eq3;
            expQ.push_back(o);
         end
         6'h02: begin o = blank(); o.pcW = 1'b1; o.mPcSrc = 3'b010; expQ.push_back(o); end
         6'h10: begin o = blank(); o.pcW = 1'b1; o.mPcSrc = 3'b100; expQ.push_back(o); end
         default: pushException(VEC_OPCODE);
      endcase
   endfunction

   // Compares the whole DUT output bundle against one expected cycle.
   task automatic checkOutput(input string tag, input outs_t expected);
      outs_t obs;
      obs = {PC_w, MEM_w, IR_w, RB_w, AB_w, ALUOut_w, EPC_w, ULA_c, M_WREG, M_WDATA,
             M_ULAA, M_ULAB, M_PC_src, Mux_addr, exc_vec};
      checks++;
      assert (obs === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expected);
      end
   endtask

   // Holds reset low for nLow cycles, checking the quiet RST state, then
   // releases it so the next edge enters FETCH1.
   task automatic applyReset(input int nLow);
      modelExcVec = 32'd0;
      reset = 1'b0;
      for (int i = 0; i < nLow; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("reset%0d", i), blank());
         checks++;
         assert (state === 5'd0) else begin
            errors++;
            $error("[TB] FAIL resetState%0d observed=%0d expected=0", i, state);
         end
      end
      reset = 1'b1;
   endtask

   // Runs one instruction from FETCH1. Flags are random except in the deciding
   // cycle. abortAt >= 0 pulls reset low during that cycle and stops there.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                input logic of3, input logic eq3, input int abortAt);
      buildExpected(op, fn, of3, eq3);
      instrNum++;
      for (int c = 0; c < expQ.size(); c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin OPCODE = op; funct = fn; end
         Of = (c == 3) ? of3 : 1'($urandom_range(1));
         Eq = (c == 3) ? eq3 : 1'($urandom_range(1));
         if (c == abortAt) reset = 1'b0;
         @(negedge clk);
         checkOutput($sformatf("i%0d op%h fn%h c%0d", instrNum, op, fn, c), expQ[c]);
         if (c == abortAt) return;
      end
   endtask

   initial begin
      logic [5:0] op;
      logic [5:0] fn;
      int         sel;

      applyReset(3);

      applyStimulus(6'h00, 6'h20, 1'b0, 1'b0, -1);   // add, no overflow
      applyStimulus(6'h08, 6'h11, 1'b1, 1'b0, -1);   // addi overflow
      applyStimulus(6'h04, 6'h00, 1'b0, 1'b1, -1);   // beq taken
      applyStimulus(6'h04, 6'h00, 1'b0, 1'b0, -1);   // beq not taken
      applyStimulus(6'h05, 6'h00, 1'b0, 1'b0, -1);   // bne taken
      applyStimulus(6'h05, 6'h00, 1'b0, 1'b1, -1);   // bne not taken
      applyStimulus(6'h23, 6'h00, 1'b1, 1'b0, -1);   // lw, Of ignored
      applyStimulus(6'h2B, 6'h00, 1'b1, 1'b0, -1);   // sw, Of ignored
      applyStimulus(6'h3F, 6'h20, 1'b0, 1'b0, -1);   // invalid opcode
      applyStimulus(6'h00, 6'h22, 1'b1, 1'b0, -1);   // sub overflow
      applyStimulus(6'h00, 6'h24, 1'b1, 1'b0, -1);   // and ignores Of
      applyStimulus(6'h00, 6'h21, 1'b0, 1'b0, -1);   // invalid funct
      applyStimulus(6'h02, 6'h00, 1'b0, 1'b0, -1);   // j
      applyStimulus(6'h10, 6'h00, 1'b0, 1'b0, -1);   // rte

      // Reset during LW_RD2: no register write, back to RST, vector cleared.
      applyStimulus(6'h23, 6'h00, 1'b0, 1'b0, 5);
      applyReset(2);
      applyStimulus(6'h00, 6'h20, 1'b0, 1'b0, -1);

      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(11);
         fn  = 6'($urandom);
         case (sel)
            0: begin op = 6'h00; fn = 6'h20; end
            1: begin op = 6'h00; fn = 6'h22; end
            2: begin op = 6'h00; fn = 6'h24; end
            3: begin
               op = 6'h00;
               while (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) fn = 6'($urandom);
            end
            4: op = 6'h08;
            5: op = 6'h23;
            6: op = 6'h2B;
            7: op = 6'h04;
            8: op = 6'h05;
            9: op = 6'h02;
            10: op = 6'h10;
            default: begin
               op = 6'($urandom);
               while (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B ||
                      op == 6'h04 || op == 6'h05 || op == 6'h02 || op == 6'h10)
                  op = 6'($urandom);
            end
         endcase
         applyStimulus(op, fn, 1'($urandom_range(1)), 1'($urandom_range(1)), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
